cpu_control_unit: RTL and testbench

- Moore FSM that sequences the 8-bit CPU datapath (PC, MAR, IR, A, B, ALU, CCR, two buses) through fetch, decode and execute.
- Drives the memory system, including the synchronous 128x8 program ROM (1-cycle read latency), with MAR as the address source.
- Implements the team instruction set: loads/stores, ALU ops, and conditional branches on NZVC.
- Sits beside data_path inside the cpu top level.

---
 rtl/cpu_pkg.sv | 80 ++++++++
 rtl/cpu_control_unit.sv | 132 +++++++++++++
 tb/tb_cpu_control_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU control path: opcodes, ALU/bus select codes,
// FSM states, NZVC bit positions and the branch condition helper.
package cpu_pkg;

   localparam logic [7:0] LDA_IMM = 8'h86;
   localparam logic [7:0] LDA_DIR = 8'h87;
   localparam logic [7:0] LDB_IMM = 8'h88;
   localparam logic [7:0] LDB_DIR = 8'h89;
   localparam logic [7:0] STA_DIR = 8'h96;
   localparam logic [7:0] STB_DIR = 8'h97;
   localparam logic [7:0] ADD_AB  = 8'h42;
   localparam logic [7:0] SUB_AB  = 8'h43;
   localparam logic [7:0] AND_AB  = 8'h44;
   localparam logic [7:0] OR_AB   = 8'h45;
   localparam logic [7:0] INCA    = 8'h46;
   localparam logic [7:0] INCB    = 8'h47;
   localparam logic [7:0] DECA    = 8'h48;
   localparam logic [7:0] DECB    = 8'h49;
   localparam logic [7:0] XOR_AB  = 8'h4A;
   localparam logic [7:0] NOTA    = 8'h4B;
   localparam logic [7:0] NOTB    = 8'h4C;
   localparam logic [7:0] BRA     = 8'h20;
   localparam logic [7:0] BMI     = 8'h21;
   localparam logic [7:0] BPL     = 8'h22;
   localparam logic [7:0] BEQ     = 8'h23;
   localparam logic [7:0] BNE     = 8'h24;
   localparam logic [7:0] BVS     = 8'h25;
   localparam logic [7:0] BVC     = 8'h26;
   localparam logic [7:0] BCS     = 8'h27;
   localparam logic [7:0] BCC     = 8'h28;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_INC = 3'b100;
   localparam logic [2:0] ALU_DEC = 3'b101;
   localparam logic [2:0] ALU_XOR = 3'b110;
   localparam logic [2:0] ALU_NOT = 3'b111;

   localparam logic [1:0] BUS1_PC   = 2'b00;
   localparam logic [1:0] BUS1_A    = 2'b01;
   localparam logic [1:0] BUS1_B    = 2'b10;
   localparam logic [1:0] BUS2_ALU  = 2'b00;
   localparam logic [1:0] BUS2_BUS1 = 2'b01;
   localparam logic [1:0] BUS2_MEM  = 2'b10;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int V_IDX = 1;
   localparam int C_IDX = 0;

   typedef enum logic [4:0] {
      S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
      S_LDI_4, S_LDI_5, S_LDI_6,
      S_LDD_4, S_LDD_5, S_LDD_6, S_LDD_7, S_LDD_8,
      S_STD_4, S_STD_5, S_STD_6, S_STD_7,
      S_DATA_4,
      S_BR_4, S_BR_5, S_BR_6, S_BRN_4
   } state_t;

   function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] nzvc);
      logic taken;
      taken = 1'b0;
      case (op)
         BRA:     taken = 1'b1;
         BMI:     taken =  nzvc[N_IDX];
         BPL:     taken = ~nzvc[N_IDX];
         BEQ:     taken =  nzvc[Z_IDX];
         BNE:     taken = ~nzvc[Z_IDX];
         BVS:     taken =  nzvc[V_IDX];
         BVC:     taken = ~nzvc[V_IDX];
         BCS:     taken =  nzvc[C_IDX];
         BCC:     taken = ~nzvc[C_IDX];
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/cpu_control_unit.sv
// Moore fetch/decode/execute sequencer for the 8-bit CPU datapath.
// Instructions take 4 (NOP) to 9 cycles; outputs decode from state and are zero in reset.
module cpu_control_unit
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] IR,
   input  logic [3:0] CCR_Result,
   output logic       IR_Load,
   output logic       MAR_Load,
   output logic       PC_Load,
   output logic       PC_Inc,
   output logic       A_Load,
   output logic       B_Load,
   output logic [2:0] ALU_Sel,
   output logic       CCR_Load,
   output logic [1:0] Bus1_Sel,
   output logic [1:0] Bus2_Sel,
   output logic       write
);

   state_t     r_state;
   logic [7:0] r_op;
   logic       w_op_is_b;

   // Opcode is latched at dispatch so execute-state outputs depend only on internal state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH_0;
         r_op    <= 8'h00;
      end else begin
         case (r_state)
            S_FETCH_0:  r_state <= S_FETCH_1;
            S_FETCH_1:  r_state <= S_FETCH_2;
            S_FETCH_2:  r_state <= S_DECODE_3;
            S_DECODE_3: begin
               r_op <= IR;
               case (IR)
                  LDA_IMM, LDB_IMM: r_state <= S_LDI_4;
                  LDA_DIR, LDB_DIR: r_state <= S_LDD_4;
                  STA_DIR, STB_DIR: r_state <= S_STD_4;
                  ADD_AB, SUB_AB, AND_AB, OR_AB, INCA, INCB,
                  DECA, DECB, XOR_AB, NOTA, NOTB: r_state <= S_DATA_4;
                  BRA, BMI, BPL, BEQ, BNE, BVS, BVC, BCS, BCC:
                     r_state <= branch_taken(IR, CCR_Result) ? S_BR_4 : S_BRN_4;
                  default: r_state <= S_FETCH_0;
               endcase
            end
            S_LDI_4:  r_state <= S_LDI_5;
            S_LDI_5:  r_state <= S_LDI_6;
            S_LDD_4:  r_state <= S_LDD_5;
            S_LDD_5:  r_state <= S_LDD_6;
            S_LDD_6:  r_state <= S_LDD_7;
            S_LDD_7:  r_state <= S_LDD_8;
            S_STD_4:  r_state <= S_STD_5;
            S_STD_5:  r_state <= S_STD_6;
            S_STD_6:  r_state <= S_STD_7;
            S_BR_4:   r_state <= S_BR_5;
            S_BR_5:   r_state <= S_BR_6;
            default:  r_state <= S_FETCH_0;
         endcase
      end
   end

   assign w_op_is_b = (r_op == LDB_IMM) || (r_op == LDB_DIR) || (r_op == STB_DIR) ||
                      (r_op == INCB) || (r_op == DECB) || (r_op == NOTB);

   always_comb begin
      IR_Load  = 1'b0;
      MAR_Load = 1'b0;
      PC_Load  = 1'b0;
      PC_Inc   = 1'b0;
      A_Load   = 1'b0;
      B_Load   = 1'b0;
      ALU_Sel  = ALU_ADD;
      CCR_Load = 1'b0;
      Bus1_Sel = BUS1_PC;
      Bus2_Sel = BUS2_ALU;
      write    = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH_0, S_LDI_4, S_LDD_4, S_STD_4, S_BR_4: begin
               Bus1_Sel = BUS1_PC;
               Bus2_Sel = BUS2_BUS1;
               MAR_Load = 1'b1;
            end
            S_FETCH_1, S_LDI_5, S_LDD_5, S_STD_5, S_BRN_4: PC_Inc = 1'b1;
            S_FETCH_2: begin
               Bus2_Sel = BUS2_MEM;
               IR_Load  = 1'b1;
            end
            S_LDD_6, S_STD_6: begin
               Bus2_Sel = BUS2_MEM;
               MAR_Load = 1'b1;
            end
            S_LDI_6, S_LDD_8: begin
               Bus2_Sel = BUS2_MEM;
               A_Load   = ~w_op_is_b;
               B_Load   =  w_op_is_b;
            end
            S_STD_7: begin
               Bus1_Sel = w_op_is_b ? BUS1_B : BUS1_A;
               write    = 1'b1;
            end
            S_DATA_4: begin
               Bus2_Sel = BUS2_ALU;
               CCR_Load = 1'b1;
               Bus1_Sel = w_op_is_b ? BUS1_B : BUS1_A;
               A_Load   = ~w_op_is_b;
               B_Load   =  w_op_is_b;
               case (r_op)
                  SUB_AB:       ALU_Sel = ALU_SUB;
                  AND_AB:       ALU_Sel = ALU_AND;
                  OR_AB:        ALU_Sel = ALU_OR;
                  XOR_AB:       ALU_Sel = ALU_XOR;
                  INCA, INCB:   ALU_Sel = ALU_INC;
                  DECA, DECB:   ALU_Sel = ALU_DEC;
                  NOTA, NOTB:   ALU_Sel = ALU_NOT;
                  default:      ALU_Sel = ALU_ADD;
               endcase
            end
            S_BR_6: begin
               Bus2_Sel = BUS2_MEM;
               PC_Load  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: per-cycle scoreboard of expected strobes,
// instruction length table, and hand-written reset sequences.
module tb_cpu_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] IR = 8'h00;
   logic [3:0] CCR_Result = 4'h0;
   logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel, Bus2_Sel;

   typedef struct packed {
      logic       ir_ld, mar_ld, pc_ld, pc_inc, a_ld, b_ld;
      logic [2:0] alu;
      logic       ccr_ld;
      logic [1:0] b1, b2;
      logic       wr;
   } out_t;

   typedef struct {
      logic [7:0] op;
      logic [3:0] ccr;
      int         len;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];
   out_t sbq[$];
   int   t_ld[$];
   int   n_chk = 0;
   int   n_fail = 0;

   cpu_control_unit dut (
      .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
      .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
      .A_Load(A_Load), .B_Load(B_Load), .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load),
      .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function out_t actual();
      return {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel,
              CCR_Load, Bus1_Sel, Bus2_Sel, write};
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t a;
      a = actual();
      n_chk++;
      if (a !== exp) begin
         n_fail++;
         $display("FAIL %s: outputs got %h want %h", name, a, exp);
      end
      n_chk++;
      if ((a.pc_ld && a.pc_inc) ||
          (a.wr && (a.ir_ld || a.mar_ld || a.pc_ld || a.a_ld || a.b_ld || a.ccr_ld))) begin
         n_fail++;
         $display("FAIL %s invariant: outputs got %h", name, a);
      end
   endtask

   function automatic out_t p_mar_pc();
      out_t e = '0;
      e.mar_ld = 1'b1; e.b1 = 2'b00; e.b2 = 2'b01;
      return e;
   endfunction

   function automatic out_t p_inc();
      out_t e = '0;
      e.pc_inc = 1'b1;
      return e;
   endfunction

   function automatic out_t p_mem();
      out_t e = '0;
      e.b2 = 2'b10;
      return e;
   endfunction

   task automatic push_instr(input logic [7:0] op, input logic [3:0] ccr);
      out_t e;
      logic tk;
      sbq.push_back(p_mar_pc());
      sbq.push_back(p_inc());
      e = p_mem(); e.ir_ld = 1'b1; sbq.push_back(e);
      e = '0; sbq.push_back(e);
      case (op) inside
         8'h86, 8'h88: begin
            sbq.push_back(p_mar_pc());
            sbq.push_back(p_inc());
            e = p_mem(); e.a_ld = (op == 8'h86); e.b_ld = (op == 8'h88); sbq.push_back(e);
         end
         8'h87, 8'h89: begin
            sbq.push_back(p_mar_pc());
            sbq.push_back(p_inc());
            e = p_mem(); e.mar_ld = 1'b1; sbq.push_back(e);
            e = '0; sbq.push_back(e);
            e = p_mem(); e.a_ld = (op == 8'h87); e.b_ld = (op == 8'h89); sbq.push_back(e);
         end
         8'h96, 8'h97: begin
            sbq.push_back(p_mar_pc());
            sbq.push_back(p_inc());
            e = p_mem(); e.mar_ld = 1'b1; sbq.push_back(e);
            e = '0; e.b1 = (op == 8'h96) ? 2'b01 : 2'b10; e.wr = 1'b1; sbq.push_back(e);
         end
         [8'h42:8'h4C]: begin
            e = '0; e.b2 = 2'b00; e.ccr_ld = 1'b1;
            case (op)
               8'h42: begin e.b1 = 2'b01; e.alu = 3'b000; e.a_ld = 1'b1; end
               8'h43: begin e.b1 = 2'b01; e.alu = 3'b001; e.a_ld = 1'b1; end
               8'h44: begin e.b1 = 2'b01; e.alu = 3'b010; e.a_ld = 1'b1; end
               8'h45: begin e.b1 = 2'b01; e.alu = 3'b011; e.a_ld = 1'b1; end
               8'h4A: begin e.b1 = 2'b01; e.alu = 3'b110; e.a_ld = 1'b1; end
               8'h46: begin e.b1 = 2'b01; e.alu = 3'b100; e.a_ld = 1'b1; end
               8'h48: begin e.b1 = 2'b01; e.alu = 3'b101; e.a_ld = 1'b1; end
               8'h4B: begin e.b1 = 2'b01; e.alu = 3'b111; e.a_ld = 1'b1; end
               8'h47: begin e.b1 = 2'b10; e.alu = 3'b100; e.b_ld = 1'b1; end
               8'h49: begin e.b1 = 2'b10; e.alu = 3'b101; e.b_ld = 1'b1; end
               default: begin e.b1 = 2'b10; e.alu = 3'b111; e.b_ld = 1'b1; end
            endcase
            sbq.push_back(e);
         end
         [8'h20:8'h28]: begin
            case (op)
               8'h20:   tk = 1'b1;
               8'h21:   tk =  ccr[3];
               8'h22:   tk = ~ccr[3];
               8'h23:   tk =  ccr[2];
               8'h24:   tk = ~ccr[2];
               8'h25:   tk =  ccr[1];
               8'h26:   tk = ~ccr[1];
               8'h27:   tk =  ccr[0];
               default: tk = ~ccr[0];
            endcase
            if (tk) begin
               sbq.push_back(p_mar_pc());
               e = '0; sbq.push_back(e);
               e = p_mem(); e.pc_ld = 1'b1; sbq.push_back(e);
            end else begin
               sbq.push_back(p_inc());
            end
         end
         default: ;
      endcase
   endtask

   initial begin
      int   li;
      int   cyc;
      out_t exp;
      out_t z;
      z = '0;

      vecs[0]  = '{8'h86, 4'b0000, 7};
      vecs[1]  = '{8'h88, 4'b0000, 7};
      vecs[2]  = '{8'h42, 4'b0000, 5};
      vecs[3]  = '{8'h47, 4'b0000, 5};
      vecs[4]  = '{8'h4A, 4'b0000, 5};
      vecs[5]  = '{8'h4C, 4'b0000, 5};
      vecs[6]  = '{8'h26, 4'b0000, 7};
      vecs[7]  = '{8'h26, 4'b0010, 5};
      vecs[8]  = '{8'h20, 4'b1111, 7};
      vecs[9]  = '{8'h23, 4'b0100, 7};
      vecs[10] = '{8'h24, 4'b0100, 5};
      vecs[11] = '{8'h96, 4'b0000, 8};
      vecs[12] = '{8'h97, 4'b0000, 8};
      vecs[13] = '{8'h87, 4'b0000, 9};
      vecs[14] = '{8'h89, 4'b0000, 9};
      vecs[15] = '{8'hFF, 4'b0000, 4};
      vecs[16] = '{8'h43, 4'b1010, 5};
      vecs[17] = '{8'h28, 4'b0001, 5};
      vecs[18] = '{8'hFF, 4'b0000, 0};

      // Reset held for two edges: all strobes low regardless of IR.
      IR = 8'h86;
      repeat (2) begin
         @(negedge clk);
         check("reset_hold", z);
      end
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < NV; i++) push_instr(vecs[i].op, vecs[i].ccr);

      li  = 0;
      cyc = 0;
      while (sbq.size() > 0 && cyc < 2000) begin
         @(negedge clk);
         exp = sbq.pop_front();
         check($sformatf("cyc%0d_op%h", cyc, (li > 0) ? vecs[li-1].op : 8'h00), exp);
         if (IR_Load) begin
            t_ld.push_back(cyc);
            if (li < NV) begin
               IR = vecs[li].op;
               CCR_Result = vecs[li].ccr;
               li++;
            end
         end
         cyc++;
      end

      n_chk++;
      if (t_ld.size() != NV) begin
         n_fail++;
         $display("FAIL ir_load_count: got %0d want %0d", t_ld.size(), NV);
      end else begin
         for (int i = 0; i < NV - 1; i++) begin
            n_chk++;
            if (t_ld[i+1] - t_ld[i] != vecs[i].len) begin
               n_fail++;
               $display("FAIL len_op%h_ccr%b: got %0d cycles want %0d",
                        vecs[i].op, vecs[i].ccr, t_ld[i+1] - t_ld[i], vecs[i].len);
            end
         end
      end

      // Reset asserted in LDD_6 of an LDA_DIR: strobes drop that cycle, fetch restarts.
      @(negedge clk); check("mid_f0", p_mar_pc());
      @(negedge clk); check("mid_f1", p_inc());
      @(negedge clk); exp = p_mem(); exp.ir_ld = 1'b1; check("mid_f2", exp);
      IR = 8'h87;
      @(negedge clk); check("mid_d3", z);
      @(negedge clk); check("mid_ldd4", p_mar_pc());
      @(negedge clk); check("mid_ldd5", p_inc());
      reset = 1'b1;
      @(negedge clk); check("mid_ldd6_reset", z);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); check("post_reset_f0", p_mar_pc());
      @(negedge clk); check("post_reset_f1", p_inc());

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
